half_adder_bank: RTL and testbench

Registered, parameterizable bank of independent half adders: each bit lane i produces Sum[i] = A[i] XOR B[i] and Cout[i] = A[i] AND B[i]. Operands enter through a valid/ready handshake and results leave through a two-entry skid-buffered output stage, so the block drops into streaming datapaths without combinational ready paths. With WIDTH = 1 it serves as the registered drop-in for the scalar half adder used in the adder library.

---
 rtl/half_adder_bank_if.sv | 23 ++
 rtl/ha_bit.sv | 10 +
 rtl/half_adder_bank.sv | 90 +++++++++
 tb/tb_half_adder_bank.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/half_adder_bank_if.sv
// Streaming operand/result bus for half_adder_bank: valid/ready in, valid/ready out.
interface half_adder_bank_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Sum;
  logic [WIDTH-1:0] Cout;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  A, B, in_valid, out_ready,
    output in_ready, Sum, Cout, out_valid
  );

  modport master (
    output A, B, in_valid, out_ready,
    input  in_ready, Sum, Cout, out_valid
  );
endinterface

// File: rtl/ha_bit.sv
// Single-lane combinational half adder.
module ha_bit (
  input  logic a_i,
  input  logic b_i,
  output logic sum_c,
  output logic cout_c
);
  assign sum_c  = a_i ^ b_i;
  assign cout_c = a_i & b_i;
endmodule

// File: rtl/half_adder_bank.sv
// Bank of WIDTH independent half adders behind an input handshake and a
// two-entry (main + skid) registered output buffer.
module half_adder_bank #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  half_adder_bank_if.slave    bus
);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic [PW-1:0]    main_q, main_d;
  logic [PW-1:0]    skid_q, skid_d;
  logic [WIDTH-1:0] sum_c, cout_c;
  logic [PW-1:0]    res_c;
  logic             accept_c, drain_c;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
    ha_bit u_ha (
      .a_i    (bus.A[i]),
      .b_i    (bus.B[i]),
      .sum_c  (sum_c[i]),
      .cout_c (cout_c[i])
    );
  end

  assign res_c    = {sum_c, cout_c};
  assign accept_c = bus.in_valid  && (state_q != S_FULL);
  assign drain_c  = bus.out_ready && (state_q != S_EMPTY);

  // Occupancy control: main always holds the FIFO head, skid the second entry.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept_c) begin
          main_d  = res_c;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept_c && drain_c) begin
          main_d = res_c;
        end else if (accept_c) begin
          skid_d  = res_c;
          state_d = S_FULL;
        end else if (drain_c) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (drain_c) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Handshake outputs decode the state register only; no path from out_ready.
  assign bus.in_ready  = (state_q != S_FULL);
  assign bus.out_valid = (state_q != S_EMPTY);
  assign bus.Sum       = main_q[PW-1:WIDTH];
  assign bus.Cout      = main_q[WIDTH-1:0];
endmodule

// File: tb/tb_half_adder_bank.sv
// Directed bench for half_adder_bank (WIDTH=1 and WIDTH=8) with a queue scoreboard.
module tb_half_adder_bank;
  logic clk;
  logic rst_n;

  half_adder_bank_if #(.WIDTH(1)) if1 ();
  half_adder_bank_if #(.WIDTH(8)) if8 ();

  half_adder_bank #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  half_adder_bank #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  q1[$];
  logic [15:0] q8[$];
  logic [1:0]  last1 = '0;
  logic [15:0] last8 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0]  v1;
    logic [15:0] v8;
    v1 = (q1.size() != 0) ? q1[0] : last1;
    v8 = (q8.size() != 0) ? q8[0] : last8;
    chk("out_valid1", 32'(if1.out_valid), 32'(q1.size() != 0));
    chk("in_ready1",  32'(if1.in_ready),  32'(q1.size() < 2));
    chk("sum1",       32'(if1.Sum),       32'(v1[1]));
    chk("cout1",      32'(if1.Cout),      32'(v1[0]));
    chk("out_valid8", 32'(if8.out_valid), 32'(q8.size() != 0));
    chk("in_ready8",  32'(if8.in_ready),  32'(q8.size() < 2));
    chk("sum8",       32'(if8.Sum),       32'(v8[15:8]));
    chk("cout8",      32'(if8.Cout),      32'(v8[7:0]));
  endtask

  // One cycle: check outputs, drive the selected DUT, advance the model at the edge.
  task automatic cyc(input bit sel8, input logic [7:0] a, input logic [7:0] b,
                     input logic v, input logic ordy);
    bit acc, drn;
    check_outputs();
    if (sel8) begin
      if8.A = a; if8.B = b; if8.in_valid = v; if8.out_ready = ordy;
      if1.A = '0; if1.B = '0; if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    end else begin
      if1.A = a[0]; if1.B = b[0]; if1.in_valid = v; if1.out_ready = ordy;
      if8.A = '0; if8.B = '0; if8.in_valid = 1'b0; if8.out_ready = 1'b1;
    end
    @(posedge clk);
    drn = (q1.size() != 0) && if1.out_ready;
    acc = if1.in_valid && (q1.size() < 2);
    if (drn) last1 = q1.pop_front();
    if (acc) q1.push_back({if1.A[0] ^ if1.B[0], if1.A[0] & if1.B[0]});
    drn = (q8.size() != 0) && if8.out_ready;
    acc = if8.in_valid && (q8.size() < 2);
    if (drn) last8 = q8.pop_front();
    if (acc) q8.push_back({if8.A ^ if8.B, if8.A & if8.B});
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if1.A = '0; if1.B = '0; if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    if8.A = '0; if8.B = '0; if8.in_valid = 1'b0; if8.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exhaustive truth table, WIDTH=1, back to back.
    cyc(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
    cyc(1'b0, 8'd0, 8'd1, 1'b1, 1'b1);
    cyc(1'b0, 8'd1, 8'd0, 1'b1, 1'b1);
    cyc(1'b0, 8'd1, 8'd1, 1'b1, 1'b1);
    cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);

    // WIDTH=8 single operand pair; explicit constant check of the result.
    cyc(1'b1, 8'hF0, 8'h3C, 1'b1, 1'b1);
    chk("f0_3c_sum",  32'(if8.Sum),  32'h0000_00CC);
    chk("f0_3c_cout", 32'(if8.Cout), 32'h0000_0030);
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);

    // Backpressure: third pair must wait until the buffer drains.
    cyc(1'b1, 8'h12, 8'h34, 1'b1, 1'b0);
    cyc(1'b1, 8'h56, 8'h78, 1'b1, 1'b0);
    cyc(1'b1, 8'h9A, 8'hBC, 1'b1, 1'b0);
    cyc(1'b1, 8'h9A, 8'hBC, 1'b1, 1'b0);
    cyc(1'b1, 8'h9A, 8'hBC, 1'b1, 1'b1);
    cyc(1'b1, 8'h9A, 8'hBC, 1'b1, 1'b1);
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);

    // Streaming: 16 random pairs with out_ready held high.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    end
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset with two entries held in the WIDTH=8 bank.
    cyc(1'b1, 8'hA5, 8'h0F, 1'b1, 1'b0);
    cyc(1'b1, 8'h3C, 8'hFF, 1'b1, 1'b0);
    check_outputs();
    #3;
    rst_n = 1'b0;
    #1;
    q1.delete(); q8.delete();
    last1 = '0; last8 = '0;
    chk("rst_out_valid8", 32'(if8.out_valid), 32'd0);
    chk("rst_sum8",       32'(if8.Sum),       32'd0);
    chk("rst_cout8",      32'(if8.Cout),      32'd0);
    check_outputs();
    if8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready8", 32'(if8.in_ready), 32'd1);

    // Idle: random operands with in_valid low leave the outputs untouched.
    cyc(1'b1, 8'h77, 8'h11, 1'b1, 1'b1);
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
